// File: rtl/mac_lane_seq_pkg.sv
// Shared types and default widths for the MAC-lane sequencer.
package mac_lane_seq_pkg;

  localparam int MAC_SEQ_ACC_W   = 16;
  localparam int MAC_SEQ_OFM_W   = 16;
  localparam int MAC_SEQ_STALL_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BIAS  = 3'd1,
    ACC   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } mac_seq_state_e;

  typedef struct packed {
    logic [MAC_SEQ_ACC_W-1:0] acc_len;
    logic [MAC_SEQ_OFM_W-1:0] ofm_cnt;
  } mac_seq_cfg_t;

  typedef struct packed {
    mac_seq_state_e             state;
    logic [MAC_SEQ_ACC_W-1:0]   beat_cnt;
    logic [MAC_SEQ_OFM_W-1:0]   ofm_idx;
    logic [MAC_SEQ_STALL_W-1:0] stall_cnt;
    logic                       busy;
  } mac_seq_monitor;

endpackage

// File: rtl/mac_lane_seq_if.sv
// Control/status bundle of one MAC-lane sequencer; the data buses are routed elsewhere.
interface mac_lane_seq_if
  import mac_lane_seq_pkg::*;
#(
  parameter int ACC_W = MAC_SEQ_ACC_W,
  parameter int OFM_W = MAC_SEQ_OFM_W
) ();

  logic             i_cfg_valid;
  logic             o_cfg_ready;
  logic [ACC_W-1:0] i_cfg_acc_len;
  logic [OFM_W-1:0] i_cfg_ofm_cnt;
  logic             i_abort;

  logic             i_up_ifm_valid;
  logic             i_up_wfm_valid;
  logic             i_up_bias_valid;
  logic             o_up_ifm_ready;
  logic             o_up_wfm_ready;
  logic             o_up_bias_ready;

  logic             o_lane_ifm_valid;
  logic             o_lane_wfm_valid;
  logic             o_lane_bias_valid;
  logic             i_lane_ifm_ready;
  logic             i_lane_wfm_ready;
  logic             i_lane_bias_ready;

  logic             i_lane_ofm_valid;
  logic             i_dn_ofm_ready;
  logic             o_lane_ofm_ready;
  logic             o_dn_ofm_valid;

  logic             o_acc_last;
  logic             o_done;
  logic             o_cfg_err;
  mac_seq_monitor   o_monitor;

  modport slave (
    input  i_cfg_valid, i_cfg_acc_len, i_cfg_ofm_cnt, i_abort,
    input  i_up_ifm_valid, i_up_wfm_valid, i_up_bias_valid,
    input  i_lane_ifm_ready, i_lane_wfm_ready, i_lane_bias_ready,
    input  i_lane_ofm_valid, i_dn_ofm_ready,
    output o_cfg_ready,
    output o_up_ifm_ready, o_up_wfm_ready, o_up_bias_ready,
    output o_lane_ifm_valid, o_lane_wfm_valid, o_lane_bias_valid,
    output o_lane_ofm_ready, o_dn_ofm_valid,
    output o_acc_last, o_done, o_cfg_err, o_monitor
  );

  modport master (
    output i_cfg_valid, i_cfg_acc_len, i_cfg_ofm_cnt, i_abort,
    output i_up_ifm_valid, i_up_wfm_valid, i_up_bias_valid,
    output i_lane_ifm_ready, i_lane_wfm_ready, i_lane_bias_ready,
    output i_lane_ofm_valid, i_dn_ofm_ready,
    input  o_cfg_ready,
    input  o_up_ifm_ready, o_up_wfm_ready, o_up_bias_ready,
    input  o_lane_ifm_valid, o_lane_wfm_valid, o_lane_bias_valid,
    input  o_lane_ofm_ready, o_dn_ofm_valid,
    input  o_acc_last, o_done, o_cfg_err, o_monitor
  );

endinterface

// File: rtl/mac_lane_seq_hs_join2.sv
// Two-input valid/ready join: a beat moves only when both producers and both consumers agree.
module mac_hs_join2 (
  input  logic en,
  input  logic a_valid,
  input  logic b_valid,
  input  logic a_ready,
  input  logic b_ready,
  output logic out_valid,
  output logic in_ready
);

  // Upstream ready also requires both valids so neither side can fire alone.
  assign out_valid = en & a_valid & b_valid;
  assign in_ready  = out_valid & a_ready & b_ready;

endmodule

// File: rtl/mac_lane_seq.sv
// MAC-lane sequencer: per command runs ofm_cnt jobs of bias, acc_len ifm/wfm beats, one ofm beat,
// gating the lane handshakes by state and reporting progress on a monitor struct.
module mac_lane_seq
  import mac_lane_seq_pkg::*;
#(
  parameter int ACC_W   = MAC_SEQ_ACC_W,
  parameter int OFM_W   = MAC_SEQ_OFM_W,
  parameter int STALL_W = MAC_SEQ_STALL_W
) (
  input logic           clk,
  input logic           rst_n,
  mac_lane_seq_if.slave bus
);

  mac_seq_state_e   state, state_nxt;
  logic [ACC_W-1:0] acc_len, beat_cnt;
  logic [OFM_W-1:0] ofm_cnt, ofm_idx;
  logic [STALL_W-1:0] stall_cnt;

  logic in_bias, in_acc, in_drain, active;
  logic cfg_fire, cfg_zero, bias_fire, acc_fire, ofm_fire, step_fire;
  logic acc_last, job_last, join_valid;

  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    return (&v) ? v : v + STALL_W'(1);
  endfunction

  assign in_bias  = (state == BIAS);
  assign in_acc   = (state == ACC);
  assign in_drain = (state == DRAIN);
  assign active   = in_bias | in_acc | in_drain;

  assign cfg_fire  = (state == IDLE) & bus.i_cfg_valid;
  assign cfg_zero  = (bus.i_cfg_acc_len == '0) | (bus.i_cfg_ofm_cnt == '0);
  assign bias_fire = in_bias & bus.i_up_bias_valid & bus.i_lane_bias_ready;
  assign ofm_fire  = in_drain & bus.i_lane_ofm_valid & bus.i_dn_ofm_ready;
  assign step_fire = bias_fire | acc_fire | ofm_fire;
  assign acc_last  = in_acc & (beat_cnt == acc_len - ACC_W'(1));
  assign job_last  = (ofm_idx == ofm_cnt - OFM_W'(1));

  mac_hs_join2 u_join (
    .en        (in_acc),
    .a_valid   (bus.i_up_ifm_valid),
    .b_valid   (bus.i_up_wfm_valid),
    .a_ready   (bus.i_lane_ifm_ready),
    .b_ready   (bus.i_lane_wfm_ready),
    .out_valid (join_valid),
    .in_ready  (acc_fire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc_len   <= '0;
      ofm_cnt   <= '0;
      beat_cnt  <= '0;
      ofm_idx   <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (bus.i_abort) begin
        beat_cnt <= '0;
        ofm_idx  <= '0;
      end else if (cfg_fire) begin
        acc_len  <= bus.i_cfg_acc_len;
        ofm_cnt  <= bus.i_cfg_ofm_cnt;
        beat_cnt <= '0;
        ofm_idx  <= '0;
      end else begin
        if (bias_fire) beat_cnt <= '0;
        if (acc_fire) beat_cnt <= beat_cnt + ACC_W'(1);
        if (ofm_fire && !job_last) ofm_idx <= ofm_idx + OFM_W'(1);
      end
      // Stall history survives an abort; only a newly accepted command clears it.
      if (cfg_fire && !bus.i_abort) stall_cnt <= '0;
      else if (active && !step_fire) stall_cnt <= sat_inc(stall_cnt);
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.i_abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (cfg_fire) state_nxt = cfg_zero ? DONE : BIAS;
        BIAS:    if (bias_fire) state_nxt = ACC;
        ACC:     if (acc_fire && acc_last) state_nxt = DRAIN;
        DRAIN:   if (ofm_fire) state_nxt = job_last ? DONE : BIAS;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.o_cfg_ready       = (state == IDLE);
    bus.o_lane_bias_valid = in_bias & bus.i_up_bias_valid;
    bus.o_up_bias_ready   = in_bias & bus.i_lane_bias_ready;
    bus.o_lane_ifm_valid  = join_valid;
    bus.o_lane_wfm_valid  = join_valid;
    bus.o_up_ifm_ready    = acc_fire;
    bus.o_up_wfm_ready    = acc_fire;
    bus.o_dn_ofm_valid    = in_drain & bus.i_lane_ofm_valid;
    bus.o_lane_ofm_ready  = in_drain & bus.i_dn_ofm_ready;
    bus.o_acc_last        = acc_last;
    bus.o_done            = (state == DONE);
    bus.o_cfg_err         = cfg_fire & cfg_zero;
    bus.o_monitor.state     = state;
    bus.o_monitor.beat_cnt  = MAC_SEQ_ACC_W'(beat_cnt);
    bus.o_monitor.ofm_idx   = MAC_SEQ_OFM_W'(ofm_idx);
    bus.o_monitor.stall_cnt = MAC_SEQ_STALL_W'(stall_cnt);
    bus.o_monitor.busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_mac_lane_seq.sv
// Bench for mac_lane_seq: directed scenarios plus random traffic against a transfer-queue model.
module tb_mac_lane_seq;
  import mac_lane_seq_pkg::*;

  typedef enum int {K_BIAS, K_ACC, K_LAST, K_OFM, K_DONE} kind_t;

  localparam int B_CFG_RDY = 0, B_UP_IFM = 1, B_UP_WFM = 2, B_UP_BIAS = 3, B_LN_IFM = 4;
  localparam int B_LN_WFM = 5, B_LN_BIAS = 6, B_LN_OFM_R = 7, B_DN_OFM_V = 8, B_LAST = 9;
  localparam int B_DONE = 10, B_ERR = 11, B_BUSY = 12;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mac_lane_seq_if #(.ACC_W(16), .OFM_W(16)) bus ();
  mac_lane_seq #(.ACC_W(16), .OFM_W(16), .STALL_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int vecs = 0;
  int errs = 0;

  // Model: the ordered list of transfers the current command still owes.
  kind_t q[$];
  int    m_stall, m_ofm, m_beat;
  logic  m_fire;
  logic [12:0]    exp_vec, obs_vec;
  mac_seq_monitor exp_mon, obs_mon, mon_mask;

  function automatic logic [12:0] pack_obs();
    return {bus.o_monitor.busy, bus.o_cfg_err, bus.o_done, bus.o_acc_last, bus.o_dn_ofm_valid,
            bus.o_lane_ofm_ready, bus.o_lane_bias_valid, bus.o_lane_wfm_valid, bus.o_lane_ifm_valid,
            bus.o_up_bias_ready, bus.o_up_wfm_ready, bus.o_up_ifm_ready, bus.o_cfg_ready};
  endfunction

  task automatic model_reset();
    q.delete();
    m_stall = 0; m_ofm = 0; m_beat = 0;
  endtask

  task automatic idle_inputs();
    bus.i_cfg_valid = 1'b0; bus.i_cfg_acc_len = '0; bus.i_cfg_ofm_cnt = '0; bus.i_abort = 1'b0;
    bus.i_up_ifm_valid = 1'b0; bus.i_up_wfm_valid = 1'b0; bus.i_up_bias_valid = 1'b0;
    bus.i_lane_ifm_ready = 1'b0; bus.i_lane_wfm_ready = 1'b0; bus.i_lane_bias_ready = 1'b0;
    bus.i_lane_ofm_valid = 1'b0; bus.i_dn_ofm_ready = 1'b0;
  endtask

  task automatic all_flow();
    bus.i_up_ifm_valid = 1'b1; bus.i_up_wfm_valid = 1'b1; bus.i_up_bias_valid = 1'b1;
    bus.i_lane_ifm_ready = 1'b1; bus.i_lane_wfm_ready = 1'b1; bus.i_lane_bias_ready = 1'b1;
    bus.i_lane_ofm_valid = 1'b1; bus.i_dn_ofm_ready = 1'b1;
  endtask

  task automatic issue_cfg(input int a, input int o);
    bus.i_cfg_valid = 1'b1;
    bus.i_cfg_acc_len = 16'(a);
    bus.i_cfg_ofm_cnt = 16'(o);
  endtask

  // Called at posedge+1 with inputs set; samples at the negedge, advances the model, returns at posedge+1.
  task automatic eval_cycle();
    kind_t h;
    logic  j;
    @(negedge clk);
    exp_vec = '0; m_fire = 1'b0; exp_mon = '0; mon_mask = '1;
    exp_mon.state = IDLE;
    if (q.size() == 0) begin
      exp_vec[B_CFG_RDY] = 1'b1;
      exp_vec[B_ERR] = bus.i_cfg_valid && (bus.i_cfg_acc_len == 0 || bus.i_cfg_ofm_cnt == 0);
    end else begin
      h = q[0];
      exp_vec[B_BUSY] = 1'b1;
      exp_mon.busy = 1'b1;
      case (h)
        K_BIAS: begin
          exp_mon.state = BIAS;
          exp_vec[B_LN_BIAS] = bus.i_up_bias_valid;
          exp_vec[B_UP_BIAS] = bus.i_lane_bias_ready;
          m_fire = bus.i_up_bias_valid & bus.i_lane_bias_ready;
        end
        K_ACC, K_LAST: begin
          exp_mon.state = ACC;
          j = bus.i_up_ifm_valid & bus.i_up_wfm_valid;
          m_fire = j & bus.i_lane_ifm_ready & bus.i_lane_wfm_ready;
          exp_vec[B_LN_IFM] = j; exp_vec[B_LN_WFM] = j;
          exp_vec[B_UP_IFM] = m_fire; exp_vec[B_UP_WFM] = m_fire;
          exp_vec[B_LAST] = (h == K_LAST);
        end
        K_OFM: begin
          exp_mon.state = DRAIN;
          exp_vec[B_DN_OFM_V] = bus.i_lane_ofm_valid;
          exp_vec[B_LN_OFM_R] = bus.i_dn_ofm_ready;
          m_fire = bus.i_lane_ofm_valid & bus.i_dn_ofm_ready;
        end
        default: begin
          exp_mon.state = DONE;
          exp_vec[B_DONE] = 1'b1;
          m_fire = 1'b1;
        end
      endcase
    end
    exp_mon.beat_cnt  = MAC_SEQ_ACC_W'(m_beat);
    exp_mon.ofm_idx   = MAC_SEQ_OFM_W'(m_ofm);
    exp_mon.stall_cnt = MAC_SEQ_STALL_W'(m_stall);
    if (exp_mon.state != ACC) mon_mask.beat_cnt = '0;
    obs_vec = pack_obs();
    obs_mon = bus.o_monitor;

    if (bus.i_abort) begin
      if (q.size() != 0 && q[0] != K_DONE && !m_fire) m_stall++;
      q.delete(); m_ofm = 0; m_beat = 0;
    end else if (q.size() == 0) begin
      if (bus.i_cfg_valid) begin
        m_stall = 0; m_ofm = 0; m_beat = 0;
        if (bus.i_cfg_acc_len != 0 && bus.i_cfg_ofm_cnt != 0) begin
          for (int o = 0; o < int'(bus.i_cfg_ofm_cnt); o++) begin
            q.push_back(K_BIAS);
            for (int a = 1; a < int'(bus.i_cfg_acc_len); a++) q.push_back(K_ACC);
            q.push_back(K_LAST);
            q.push_back(K_OFM);
          end
        end
        q.push_back(K_DONE);
      end
    end else begin
      if (q[0] != K_DONE && !m_fire) m_stall++;
      if (m_fire) begin
        h = q.pop_front();
        if (h == K_BIAS) m_beat = 0;
        else if (h == K_ACC || h == K_LAST) m_beat++;
        else if (h == K_OFM && q[0] == K_BIAS) m_ofm++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    obs_vec = pack_obs();
    obs_mon = bus.o_monitor;
    vecs++;
    if (obs_vec !== 13'h0001) begin
      errs++; $display("FAIL reset_outputs got=%h exp=%h", obs_vec, 13'h0001);
    end
    vecs++;
    if (obs_mon !== '0) begin
      errs++; $display("FAIL reset_monitor got=%h exp=0", obs_mon);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    int done_at = -1;
    int nb = 0, na = 0, no = 0, last_mask = 0;
    idle_inputs(); all_flow(); issue_cfg(4, 2);
    for (int c = 0; c < 20; c++) begin
      eval_cycle();
      bus.i_cfg_valid = 1'b0;
      vecs++;
      if ({obs_vec, obs_mon & mon_mask} !== {exp_vec, exp_mon & mon_mask}) begin
        errs++; $display("FAIL basic c=%0d got=%h/%h exp=%h/%h", c, obs_vec, obs_mon & mon_mask, exp_vec, exp_mon & mon_mask);
      end
      if (obs_vec[B_UP_BIAS]) nb++;
      if (obs_vec[B_UP_IFM]) begin
        na++;
        if (obs_vec[B_LAST]) last_mask |= (1 << na);
      end
      if (obs_vec[B_LN_OFM_R]) no++;
      if (obs_vec[B_DONE] && done_at < 0) done_at = c;
    end
    vecs++;
    if (nb !== 2 || na !== 8 || no !== 2) begin
      errs++; $display("FAIL basic_counts got bias=%0d acc=%0d ofm=%0d exp 2/8/2", nb, na, no);
    end
    vecs++;
    if (last_mask !== ((1 << 4) | (1 << 8))) begin
      errs++; $display("FAIL basic_acc_last got=%h exp=%h", last_mask, (1 << 4) | (1 << 8));
    end
    vecs++;
    if (done_at !== 1 + 2 * (4 + 2)) begin
      errs++; $display("FAIL basic_done_cycle got=%0d exp=%0d", done_at, 1 + 2 * (4 + 2));
    end
  endtask

  task automatic test_lag();
    int lag = 0, done_stall = -1;
    idle_inputs(); all_flow(); issue_cfg(3, 1);
    bus.i_up_wfm_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      eval_cycle();
      bus.i_cfg_valid = 1'b0;
      vecs++;
      if ({obs_vec, obs_mon & mon_mask} !== {exp_vec, exp_mon & mon_mask}) begin
        errs++; $display("FAIL lag c=%0d got=%h/%h exp=%h/%h", c, obs_vec, obs_mon & mon_mask, exp_vec, exp_mon & mon_mask);
      end
      vecs++;
      if (obs_vec[B_UP_IFM] && !bus.i_up_wfm_valid) begin
        errs++; $display("FAIL lag_ifm_alone c=%0d up_ifm_ready=1 with wfm_valid=0", c);
      end
      if (obs_vec[B_DONE]) done_stall = int'(obs_mon.stall_cnt);
      if (obs_mon.state != ACC || obs_vec[B_UP_IFM]) lag = 0;
      else lag++;
      bus.i_up_wfm_valid = (lag >= 2);
    end
    vecs++;
    if (done_stall !== 6) begin
      errs++; $display("FAIL lag_stall got=%0d exp=6", done_stall);
    end
  endtask

  task automatic test_zero();
    int nerr = 0, ndone = 0, nrdy = 0;
    idle_inputs(); all_flow(); issue_cfg(0, 5);
    for (int c = 0; c < 6; c++) begin
      eval_cycle();
      bus.i_cfg_valid = 1'b0;
      vecs++;
      if ({obs_vec, obs_mon & mon_mask} !== {exp_vec, exp_mon & mon_mask}) begin
        errs++; $display("FAIL zero c=%0d got=%h/%h exp=%h/%h", c, obs_vec, obs_mon & mon_mask, exp_vec, exp_mon & mon_mask);
      end
      nerr += int'(obs_vec[B_ERR]);
      ndone += int'(obs_vec[B_DONE]);
      nrdy += int'(obs_vec[B_UP_IFM] | obs_vec[B_UP_WFM] | obs_vec[B_UP_BIAS] | obs_vec[B_LN_OFM_R]);
    end
    vecs++;
    if (nerr !== 1 || ndone !== 1 || nrdy !== 0) begin
      errs++; $display("FAIL zero_pulses got err=%0d done=%0d readies=%0d exp 1/1/0", nerr, ndone, nrdy);
    end
  endtask

  task automatic test_abort();
    int ndone = 0;
    idle_inputs(); all_flow(); issue_cfg(2, 3);
    for (int c = 0; c < 14; c++) begin
      bus.i_abort = (c == 7);
      eval_cycle();
      bus.i_cfg_valid = 1'b0;
      vecs++;
      if ({obs_vec, obs_mon & mon_mask} !== {exp_vec, exp_mon & mon_mask}) begin
        errs++; $display("FAIL abort c=%0d got=%h/%h exp=%h/%h", c, obs_vec, obs_mon & mon_mask, exp_vec, exp_mon & mon_mask);
      end
      if (c == 7) begin
        vecs++;
        if (obs_mon.state != ACC || obs_mon.ofm_idx != 1 || obs_mon.beat_cnt != 1) begin
          errs++; $display("FAIL abort_point got st=%0d ofm=%0d beat=%0d exp 2/1/1", obs_mon.state, obs_mon.ofm_idx, obs_mon.beat_cnt);
        end
      end
      if (c == 8) begin
        vecs++;
        if (obs_mon.state != IDLE || obs_vec[B_CFG_RDY] !== 1'b1) begin
          errs++; $display("FAIL abort_idle got st=%0d cfg_ready=%b exp 0/1", obs_mon.state, obs_vec[B_CFG_RDY]);
        end
      end
      ndone += int'(obs_vec[B_DONE]);
    end
    vecs++;
    if (ndone !== 0) begin
      errs++; $display("FAIL abort_done got=%0d exp=0", ndone);
    end
  endtask

  task automatic test_drain_stall();
    int drain_seen = 0, done_stall = -1;
    idle_inputs(); all_flow(); issue_cfg(1, 1);
    for (int c = 0; c < 20; c++) begin
      bus.i_dn_ofm_ready = (drain_seen >= 10);
      eval_cycle();
      bus.i_cfg_valid = 1'b0;
      vecs++;
      if ({obs_vec, obs_mon & mon_mask} !== {exp_vec, exp_mon & mon_mask}) begin
        errs++; $display("FAIL drain c=%0d got=%h/%h exp=%h/%h", c, obs_vec, obs_mon & mon_mask, exp_vec, exp_mon & mon_mask);
      end
      if (obs_mon.state == DRAIN) drain_seen++;
      if (obs_vec[B_DONE]) done_stall = int'(obs_mon.stall_cnt);
    end
    vecs++;
    if (drain_seen !== 11 || done_stall !== 10) begin
      errs++; $display("FAIL drain_hold got drain=%0d stall=%0d exp 11/10", drain_seen, done_stall);
    end
  endtask

  task automatic test_rst_mid();
    int ndone = 0;
    idle_inputs(); all_flow(); issue_cfg(5, 1);
    for (int c = 0; c < 4; c++) begin
      eval_cycle();
      bus.i_cfg_valid = 1'b0;
      vecs++;
      if ({obs_vec, obs_mon & mon_mask} !== {exp_vec, exp_mon & mon_mask}) begin
        errs++; $display("FAIL rstmid c=%0d got=%h/%h exp=%h/%h", c, obs_vec, obs_mon & mon_mask, exp_vec, exp_mon & mon_mask);
      end
    end
    rst_n = 1'b0;
    #1;
    obs_vec = pack_obs();
    obs_mon = bus.o_monitor;
    vecs++;
    if (obs_vec !== 13'h0001 || obs_mon !== '0) begin
      errs++; $display("FAIL rstmid_async got=%h/%h exp=0001/0", obs_vec, obs_mon);
    end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    issue_cfg(1, 1);
    for (int c = 0; c < 8; c++) begin
      eval_cycle();
      bus.i_cfg_valid = 1'b0;
      vecs++;
      if ({obs_vec, obs_mon & mon_mask} !== {exp_vec, exp_mon & mon_mask}) begin
        errs++; $display("FAIL rstmid_new c=%0d got=%h/%h exp=%h/%h", c, obs_vec, obs_mon & mon_mask, exp_vec, exp_mon & mon_mask);
      end
      ndone += int'(obs_vec[B_DONE]);
    end
    vecs++;
    if (ndone !== 1) begin
      errs++; $display("FAIL rstmid_done got=%0d exp=1", ndone);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      int guard = 0;
      idle_inputs();
      issue_cfg($urandom_range(0, 4), $urandom_range(1, 3));
      do begin
        bus.i_up_ifm_valid   = ($urandom_range(0, 3) != 0);
        bus.i_up_wfm_valid   = ($urandom_range(0, 3) != 0);
        bus.i_up_bias_valid  = ($urandom_range(0, 3) != 0);
        bus.i_lane_ifm_ready = ($urandom_range(0, 3) != 0);
        bus.i_lane_wfm_ready = ($urandom_range(0, 3) != 0);
        bus.i_lane_bias_ready = ($urandom_range(0, 3) != 0);
        bus.i_lane_ofm_valid = ($urandom_range(0, 3) != 0);
        bus.i_dn_ofm_ready   = ($urandom_range(0, 3) != 0);
        bus.i_abort          = ($urandom_range(0, 79) == 0);
        eval_cycle();
        bus.i_cfg_valid = 1'b0;
        guard++;
        vecs++;
        if ({obs_vec, obs_mon & mon_mask} !== {exp_vec, exp_mon & mon_mask}) begin
          errs++; $display("FAIL random n=%0d c=%0d got=%h/%h exp=%h/%h", n, guard, obs_vec, obs_mon & mon_mask, exp_vec, exp_mon & mon_mask);
        end
      end while (q.size() != 0 && guard < 400);
      vecs++;
      if (q.size() != 0) begin
        errs++; $display("FAIL random_timeout n=%0d pending=%0d exp=0", n, q.size());
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t limit=200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_lag();
    test_zero();
    test_abort();
    test_drain_stall();
    test_rst_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
